// File: rtl/alu_imm_unit_if.sv
// Execute-stage bus bundle for the OP-IMM handler.
// The slave modport is the handler; the master modport is the side that owns
// the decoder select, the instruction word, the register file and the ALU.
//
// Bus semantics: there is no valid/ready handshake. While enable_n is low the
// handler drives register_src, alu_a, alu_b, alu_op, alu_signal, register_dest
// and register_dest_data combinationally in the same cycle. While enable_n is
// high it releases all of them to high-Z so that other handlers can share the
// bus. illegal is always driven.
interface alu_imm_unit_if #(
    parameter int XLEN           = 32,
    parameter int REG_SELECT_LEN = 5
);
    logic                      enable_n;
    logic [XLEN-1:0]           instruction;
    logic [XLEN-1:0]           register_src_data;
    logic [XLEN-1:0]           alu_out;

    wire  [REG_SELECT_LEN-1:0] register_src;
    wire  [XLEN-1:0]           alu_a;
    wire  [XLEN-1:0]           alu_b;
    wire  [2:0]                alu_op;
    wire                       alu_signal;
    wire  [REG_SELECT_LEN-1:0] register_dest;
    wire  [XLEN-1:0]           register_dest_data;

    logic                      illegal;

    modport slave (
        input  enable_n, instruction, register_src_data, alu_out,
        output register_src, alu_a, alu_b, alu_op, alu_signal,
               register_dest, register_dest_data, illegal
    );

    modport master (
        output enable_n, instruction, register_src_data, alu_out,
        input  register_src, alu_a, alu_b, alu_op, alu_signal,
               register_dest, register_dest_data, illegal
    );
endinterface

// File: rtl/alu_imm_unit.sv
// OP-IMM execute handler (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI).
// Requests rs1, feeds the external ALU and returns its result for rd, all
// combinationally; every bus output floats while the unit is not selected.
// Optional macro ALU_IMM_ILLEGAL_CHECK_EN adds a registered illegal-encoding
// flag; without it the illegal output is a constant 0 and no flop exists.
module alu_imm_unit #(
    parameter int XLEN           = 32,
    parameter int REG_SELECT_LEN = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_imm_unit_if.slave      bus
);

    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_b_val;
    logic            alu_signal_val;

    assign funct3 = bus.instruction[14:12];

    // Choose the operand-B form and ALU variant: shifts take a zero-extended
    // shamt and only SRAI sets the variant bit; everything else uses the
    // sign-extended 12-bit immediate and never subtracts.
    always_comb begin
        alu_b_val      = {{(XLEN-12){bus.instruction[31]}}, bus.instruction[31:20]};
        alu_signal_val = 1'b0;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
            alu_b_val = {{(XLEN-5){1'b0}}, bus.instruction[24:20]};
        end
        if (funct3 == 3'b101) begin
            alu_signal_val = bus.instruction[30];
        end
    end

    // Shared-bus drivers: released to high-Z whenever the unit is deselected.
    assign bus.register_src       = bus.enable_n ? {REG_SELECT_LEN{1'bz}}
                                                 : REG_SELECT_LEN'(bus.instruction[19:15]);
    assign bus.register_dest      = bus.enable_n ? {REG_SELECT_LEN{1'bz}}
                                                 : REG_SELECT_LEN'(bus.instruction[11:7]);
    assign bus.alu_a              = bus.enable_n ? {XLEN{1'bz}} : bus.register_src_data;
    assign bus.alu_b              = bus.enable_n ? {XLEN{1'bz}} : alu_b_val;
    assign bus.alu_op             = bus.enable_n ? 3'bzzz : funct3;
    assign bus.alu_signal         = bus.enable_n ? 1'bz : alu_signal_val;
    assign bus.register_dest_data = bus.enable_n ? {XLEN{1'bz}} : bus.alu_out;

`ifdef ALU_IMM_ILLEGAL_CHECK_EN
    logic [6:0] funct7;
    logic       bad_encoding;
    logic       illegal_d;
    logic       illegal_q;

    assign funct7 = bus.instruction[31:25];

    // Flag words outside OP-IMM and shifts carrying a reserved funct7.
    always_comb begin
        bad_encoding = 1'b0;
        if (bus.instruction[6:0] != 7'b0010011) begin
            bad_encoding = 1'b1;
        end
        if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
            bad_encoding = 1'b1;
        end
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
            bad_encoding = 1'b1;
        end
    end

    assign illegal_d = !bus.enable_n && bad_encoding;

    // One-cycle, non-sticky flag; reset wins over a simultaneous bad encoding.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign bus.illegal = illegal_q;
`else
    logic unused_ok;

    assign bus.illegal = 1'b0;
    // clk, reset and the opcode field only matter when the check is built in.
    assign unused_ok   = &{1'b0, clk, reset, bus.instruction[6:0]};
`endif

endmodule

// File: tb/tb_alu_imm_unit.sv
// Bench for alu_imm_unit: directed vectors from the OP-IMM decode rules plus
// randomized instructions, checked against an ISA-level reference model that
// also stands in for the external ALU.
module tb_alu_imm_unit;

    localparam int XLEN = 32;
    localparam int RSL  = 5;

    logic clk;
    logic reset;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [0:0]  exp_q[$];
    logic [31:0] z32;

    alu_imm_unit_if #(.XLEN(XLEN), .REG_SELECT_LEN(RSL)) bus ();

    alu_imm_unit #(.XLEN(XLEN), .REG_SELECT_LEN(RSL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model, written from the RISC-V OP-IMM definition.
    function automatic logic [31:0] ref_operand_b(input logic [31:0] instr);
        int imm;
        logic [2:0] f3;
        f3 = instr[14:12];
        if (f3 == 3'd1 || f3 == 3'd5) begin
            return 32'(instr[24:20]);
        end
        imm = int'(instr[31:20]);
        if (imm >= 2048) imm = imm - 4096;
        return 32'(imm);
    endfunction

    function automatic logic ref_variant(input logic [31:0] instr);
        return (instr[14:12] == 3'd5) ? instr[30] : 1'b0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic sub,
                                             input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return sub ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return sub ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_bad(input logic [31:0] instr);
`ifdef ALU_IMM_ILLEGAL_CHECK_EN
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = instr[31:25];
        f3 = instr[14:12];
        if (instr[6:0] != 7'h13) return 1'b1;
        if (f3 == 3'd1 && f7 != 7'h00) return 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return 1'b1;
        return 1'b0;
`else
        return (instr == 32'hFFFF_FFFF) && (instr != 32'hFFFF_FFFF);
`endif
    endfunction

    // Driver: apply one vector just after a rising edge, the paired ALU answers.
    task automatic apply_vec(input logic rst, input logic en_n,
                             input logic [31:0] instr, input logic [31:0] rs1);
        reset                 = rst;
        bus.enable_n          = en_n;
        bus.instruction       = instr;
        bus.register_src_data = rs1;
        bus.alu_out           = ref_alu(instr[14:12], ref_variant(instr), rs1, ref_operand_b(instr));
        exp_q.push_back(rst ? 1'b0 : (!en_n && ref_bad(instr)));
        @(negedge clk);
    endtask

    // Combinational bus checks at the falling edge.
    task automatic check_comb();
        logic [31:0] instr;
        instr = bus.instruction;
        if (bus.enable_n) begin
            check("rs_z",    32'(bus.register_src),       32'(z32[4:0]));
            check("rd_z",    32'(bus.register_dest),      32'(z32[4:0]));
            check("a_z",     bus.alu_a,                   z32);
            check("b_z",     bus.alu_b,                   z32);
            check("op_z",    32'(bus.alu_op),             32'(z32[2:0]));
            check("sig_z",   32'(bus.alu_signal),         32'(z32[0]));
            check("wd_z",    bus.register_dest_data,      z32);
        end else begin
            check("rs",      32'(bus.register_src),       32'(instr[19:15]));
            check("rd",      32'(bus.register_dest),      32'(instr[11:7]));
            check("a",       bus.alu_a,                   bus.register_src_data);
            check("b",       bus.alu_b,                   ref_operand_b(instr));
            check("op",      32'(bus.alu_op),             32'(instr[14:12]));
            check("sig",     32'(bus.alu_signal),         32'(ref_variant(instr)));
            check("wd",      bus.register_dest_data,
                  ref_alu(instr[14:12], ref_variant(instr), bus.register_src_data,
                          ref_operand_b(instr)));
        end
    endtask

    // Registered flag check one cycle after the vector was applied.
    task automatic finish_cycle();
        logic [0:0] e;
        @(posedge clk);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        check("illegal", 32'(bus.illegal), 32'(e));
    endtask

    task automatic run_vec(input logic rst, input logic en_n,
                           input logic [31:0] instr, input logic [31:0] rs1);
        apply_vec(rst, en_n, instr, rs1);
        check_comb();
        finish_cycle();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3;
        int          pick;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) return w;
        w[6:0] = 7'h13;
        f3 = w[14:12];
        if (f3 == 3'd1 || f3 == 3'd5) begin
            pick = $urandom_range(0, 2);
            if (pick == 0) w[31:25] = 7'h00;
            else if (pick == 1) w[31:25] = 7'h20;
        end
        return w;
    endfunction

    initial begin
        z32                   = 'z;
        reset                 = 1'b1;
        bus.enable_n          = 1'b1;
        bus.instruction       = 32'h0;
        bus.register_src_data = 32'h0;
        bus.alu_out           = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_illegal", 32'(bus.illegal), 32'd0);

        // ADDI x5,x1,-1
        apply_vec(1'b0, 1'b0, 32'hFFF08293, 32'h0000_0010);
        check_comb();
        check("addi_rs", 32'(bus.register_src),  32'h01);
        check("addi_a",  bus.alu_a,              32'h0000_0010);
        check("addi_b",  bus.alu_b,              32'hFFFF_FFFF);
        check("addi_op", 32'(bus.alu_op),        32'd0);
        check("addi_sg", 32'(bus.alu_signal),    32'd0);
        check("addi_rd", 32'(bus.register_dest), 32'h05);
        check("addi_wd", bus.register_dest_data, 32'h0000_000F);
        finish_cycle();

        // SRAI x3,x2,4 paired with the ALU model
        apply_vec(1'b0, 1'b0, 32'h40415193, 32'h8000_0000);
        check_comb();
        check("srai_rs", 32'(bus.register_src),  32'h02);
        check("srai_b",  bus.alu_b,              32'h0000_0004);
        check("srai_op", 32'(bus.alu_op),        32'd5);
        check("srai_sg", 32'(bus.alu_signal),    32'd1);
        check("srai_rd", 32'(bus.register_dest), 32'h03);
        check("srai_wd", bus.register_dest_data, 32'hF800_0000);
        finish_cycle();

        // SLLI x1,x1,31
        apply_vec(1'b0, 1'b0, 32'h01F09093, 32'h1234_5678);
        check_comb();
        check("slli_b",  bus.alu_b,              32'h0000_001F);
        check("slli_op", 32'(bus.alu_op),        32'd1);
        check("slli_sg", 32'(bus.alu_signal),    32'd0);
        check("slli_rd", 32'(bus.register_dest), 32'h01);
        finish_cycle();

        // ANDI x2,x3,0x7FF
        apply_vec(1'b0, 1'b0, 32'h7FF1F113, 32'hDEAD_BEEF);
        check_comb();
        check("andi_b",  bus.alu_b,              32'h0000_07FF);
        check("andi_op", 32'(bus.alu_op),        32'd7);
        check("andi_rs", 32'(bus.register_src),  32'h03);
        finish_cycle();

        // Deselected: everything floats, flag stays low even for a bad word.
        run_vec(1'b0, 1'b1, 32'hFFF08293, 32'h0000_0010);
        run_vec(1'b0, 1'b1, 32'h41F09093, 32'h0000_0010);

        // Reserved SLLI funct7: flag, then reset priority, then a clean word.
        run_vec(1'b0, 1'b0, 32'h41F09093, 32'h0000_0001);
        run_vec(1'b1, 1'b0, 32'h41F09093, 32'h0000_0001);
        run_vec(1'b0, 1'b0, 32'h01F09093, 32'h0000_0001);
        // Non-OP-IMM opcode and reserved SRxI funct7.
        run_vec(1'b0, 1'b0, 32'h00000033, 32'h0000_0001);
        run_vec(1'b0, 1'b0, 32'h60415193, 32'h0000_0001);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            run_vec($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                    rand_instr(), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
